csc_matrix: RTL
===============

CSC_MATRIX -- requirements
Module: csc_matrix

Interface
REQ-001 Parameter: PIXEL_WIDTH, default 8, channel width in and out.
REQ-002 Parameter: COEF_WIDTH, default 12, signed two's-complement coefficient width.
REQ-003 Parameter: COEF_FRAC, default 8, fractional bits of coefficients; legal range 8..COEF_WIDTH-2.
REQ-004 Port: clk  in  1  single clock; all logic on posedge.
REQ-005 Port: resetb  in  1  reset, synchronous and active-low.
REQ-006 Port: enable  in  1  1 = matrix convert, 0 = bypass.
REQ-007 Port: dvi  in  1  input beat valid.
REQ-008 Port: dtypei  in  DTYPE_WIDTH  input data type, codes from shared dtype definitions.
REQ-009 Port: i0, i1, i2  in  PIXEL_WIDTH each  input channels (R,G,B or Y,U,V).
REQ-010 Port: meta_datai  in  16  sideband, passed through.
REQ-011 Port: cfg_we  in  1  config write strobe.
REQ-012 Port: cfg_addr  in  4  config register address.
REQ-013 Port: cfg_wdata  in  16  config write data.
REQ-014 Port: dvo, dtypeo, o0, o1, o2, meta_datao  out  widths matching inputs  registered outputs.
REQ-015 Port: cfg_pending  out  1  shadow bank committed but not yet active.

Function
REQ-016 Config map: addr 0..8 = shadow coefficients C[row][col] row-major (low COEF_WIDTH bits of cfg_wdata); addr 9..11 = shadow offsets K0..K2 (low PIXEL_WIDTH+1 bits, signed); addr 12 = OUT_SIGNED mask (bits 2:0) plus commit; addr 13 = commit only; addr 14..15 ignored.
REQ-017 Writes to addr 0..12 update shadow only; active bank never changes on those writes.
REQ-018 Commit (write to 12 or 13) sets cfg_pending=1 the following cycle.
REQ-019 Shadow-to-active copy on any cycle with cfg_pending=1 and either (dvi=1 and dtypei=frame-start code) or enable=0; cfg_pending clears the same edge.
REQ-020 Commit coinciding with a transfer cycle: transfer uses shadow contents including that cycle's write; cfg_pending ends at 0.
REQ-021 Beats accepted in the transfer cycle and after use the new active bank; earlier beats still in the pipeline keep the old bank.
REQ-022 Compute per row r: acc = sum(C[r][c]*i_c, i unsigned) + 2^(COEF_FRAC-1); arithmetic shift right COEF_FRAC; add sign-extended K_r; no intermediate overflow (acc width >= PIXEL_WIDTH+COEF_WIDTH+3).
REQ-023 Clamp row r: OUT_SIGNED[r]=0 -> [0, 2^PIXEL_WIDTH-1]; OUT_SIGNED[r]=1 -> [-2^(PIXEL_WIDTH-1), 2^(PIXEL_WIDTH-1)-1], two's-complement output.
REQ-024 Pipeline: stage1 products, stage2 sum/round/shift/offset, stage3 clamp into output registers; latency exactly 3 cycles, one beat per cycle, no stall.
REQ-025 dvo, dtypeo, meta_datao delayed 3 cycles in lockstep with data regardless of enable.
REQ-026 Bypass (enable=0 at input): o0..o2 = i0..i2 unchanged, same 3-cycle latency; enable sampled per beat, mid-stream toggling is beat-accurate.
REQ-027 Non-valid beats (dvi=0) still propagate; data on them is don't-care but deterministic.

Reset
REQ-028 On resetb=0 at posedge: dvo=0, dtypeo=0, meta_datao=0, o0..o2=0, all pipeline valid bits 0, cfg_pending=0.
REQ-029 Active and shadow banks reset to BT.601: row0 (66,129,25), row1 (-38,-74,112), row2 (112,-94,-18), each scaled by 2^(COEF_FRAC-8); K=0; OUT_SIGNED=3'b110.
REQ-030 Reset mid-stream discards in-flight beats; no beat emerges from pre-reset inputs.

Structure
REQ-031 Config address constants, default coefficient values and OUT_SIGNED default live in the shared imager definitions package; frame-start code from the shared dtype definitions.
REQ-032 One sub-module csc_row (one row: 3 multiplies, sum, round, offset, clamp, 3 stages) instantiated three times; top holds config banks and sideband delay.

Verification
REQ-033 Defaults, PW=8, input (255,255,255) -> 3 cycles later (219, 0x00, 0x00); (0,0,0) -> (0,0,0).
REQ-034 Defaults, input (255,0,0) -> (66, 0xDA, 0x70).
REQ-035 Row0 = (512,0,0), row1 = (-512,0,0), commit, frame-start, input r=200 -> o0=255 (unsigned clamp), o1=0x80 (signed clamp).
REQ-036 Mid-frame write of new row0 + commit -> cfg_pending=1, outputs unchanged until frame-start beat; beats from frame-start onward use new row0.
REQ-037 enable=0 for one beat inside a stream -> that beat emerges unchanged, neighbours converted, dvo/dtypeo/meta_datao aligned.
REQ-038 resetb=0 for one cycle with 3 beats in flight and cfg_pending=1 -> next cycle dvo=0, cfg_pending=0, defaults restored, no stale beats.

Source files
------------

// File: rtl/csc_matrix_pkg.sv
// Shared definitions for the colour-space-conversion matrix.
//   - Data-type codes carried on dtypei/dtypeo alongside every beat.
//   - Configuration register map (shadow coefficients, offsets, sign mask, commit).
//   - Reset-default BT.601 coefficient set and OUT_SIGNED mask.
package csc_matrix_pkg;

    localparam int unsigned DTYPE_WIDTH = 4;

    typedef enum logic [DTYPE_WIDTH-1:0] {
        DtypeIdle       = 4'd0,
        DtypeFrameStart = 4'd1,
        DtypeLineStart  = 4'd2,
        DtypeData       = 4'd3,
        DtypeFrameEnd   = 4'd4
    } dtype_e;

    // Config map: 0..8 coefficients (row-major), 9..11 offsets, 12 sign mask + commit,
    // 13 commit only, 14..15 ignored.
    localparam int unsigned NUM_COEF       = 9;
    localparam logic [3:0]  CfgAddrOff0    = 4'd9;
    localparam logic [3:0]  CfgAddrSigned  = 4'd12;
    localparam logic [3:0]  CfgAddrCommit  = 4'd13;

    // Rows 1 and 2 (chroma) are signed by default, row 0 (luma) is unsigned.
    localparam logic [2:0]  DefOutSigned   = 3'b110;

    // BT.601 coefficients at 8 fractional bits, rescaled to the configured precision.
    function automatic int default_coef(input int idx, input int frac);
        int base;
        case (idx)
            0:       base = 66;
            1:       base = 129;
            2:       base = 25;
            3:       base = -38;
            4:       base = -74;
            5:       base = 112;
            6:       base = 112;
            7:       base = -94;
            8:       base = -18;
            default: base = 0;
        endcase
        return base * (1 << (frac - 8));
    endfunction

endpackage

// File: rtl/csc_matrix_row.sv
// csc_row: one output row of the colour matrix, three register stages.
//   Stage 1: three signed x unsigned products.
//   Stage 2: sum, round-half-up, arithmetic shift, add signed offset.
//   Stage 3: clamp to unsigned or signed pixel range into the output register.
// The per-beat bank (coefficients, offset, sign flag) and bypass flag travel with the
// beat so a bank switch never affects beats already in flight.
// Ports:
//   clk, resetb     clock, synchronous active-low reset
//   bypass_i        1 = emit pass_i unchanged
//   pix_i           the three input channels (unsigned)
//   pass_i          this row's own input channel, used in bypass
//   coef_i          this row's three coefficients (signed)
//   offset_i        signed offset K, PIXEL_WIDTH+1 bits
//   out_signed_i    1 = signed output clamp
//   pix_o           registered result
module csc_row #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned COEF_WIDTH  = 12,
    parameter int unsigned COEF_FRAC   = 8
) (
    input  logic                         clk,
    input  logic                         resetb,
    input  logic                         bypass_i,
    input  logic [2:0][PIXEL_WIDTH-1:0]  pix_i,
    input  logic [PIXEL_WIDTH-1:0]       pass_i,
    input  logic [2:0][COEF_WIDTH-1:0]   coef_i,
    input  logic [PIXEL_WIDTH:0]         offset_i,
    input  logic                         out_signed_i,
    output logic [PIXEL_WIDTH-1:0]       pix_o
);

    localparam int unsigned ProdW = COEF_WIDTH + PIXEL_WIDTH + 1;
    localparam int unsigned AccW  = PIXEL_WIDTH + COEF_WIDTH + 3;

    localparam logic signed [AccW-1:0] Round = AccW'(64'd1 << (COEF_FRAC - 1));
    localparam logic signed [AccW-1:0] UMax  = AccW'((64'd1 << PIXEL_WIDTH) - 64'd1);
    localparam logic signed [AccW-1:0] SMax  = AccW'((64'd1 << (PIXEL_WIDTH - 1)) - 64'd1);
    localparam logic signed [AccW-1:0] SMin  = ~SMax;

    // Stage 1
    logic signed [ProdW-1:0]       prod_d [3];
    logic signed [ProdW-1:0]       prod_q [3];
    logic                          byp1_q;
    logic [PIXEL_WIDTH-1:0]        pass1_q;
    logic signed [PIXEL_WIDTH:0]   off1_q;
    logic                          sgn1_q;

    // Stage 2
    logic signed [AccW-1:0]        sum;
    logic signed [AccW-1:0]        val_d;
    logic signed [AccW-1:0]        val_q;
    logic                          byp2_q;
    logic [PIXEL_WIDTH-1:0]        pass2_q;
    logic                          sgn2_q;

    // Stage 3
    logic [PIXEL_WIDTH-1:0]        out_d;
    logic [PIXEL_WIDTH-1:0]        out_q;

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            // Zero-extend the pixel so it multiplies as a non-negative signed value.
            prod_d[c] = ProdW'($signed(coef_i[c])) * ProdW'($signed({1'b0, pix_i[c]}));
        end
    end

    always_comb begin
        sum   = AccW'(prod_q[0]) + AccW'(prod_q[1]) + AccW'(prod_q[2]) + Round;
        val_d = (sum >>> COEF_FRAC) + AccW'(off1_q);
    end

    always_comb begin
        out_d = val_q[PIXEL_WIDTH-1:0];
        if (byp2_q) begin
            out_d = pass2_q;
        end else if (sgn2_q) begin
            if (val_q > SMax) begin
                out_d = SMax[PIXEL_WIDTH-1:0];
            end else if (val_q < SMin) begin
                out_d = SMin[PIXEL_WIDTH-1:0];
            end
        end else begin
            if (val_q > UMax) begin
                out_d = UMax[PIXEL_WIDTH-1:0];
            end else if (val_q < 0) begin
                out_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            for (int c = 0; c < 3; c++) begin
                prod_q[c] <= '0;
            end
            byp1_q  <= 1'b0;
            pass1_q <= '0;
            off1_q  <= '0;
            sgn1_q  <= 1'b0;
            val_q   <= '0;
            byp2_q  <= 1'b0;
            pass2_q <= '0;
            sgn2_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                prod_q[c] <= prod_d[c];
            end
            byp1_q  <= bypass_i;
            pass1_q <= pass_i;
            off1_q  <= $signed(offset_i);
            sgn1_q  <= out_signed_i;
            val_q   <= val_d;
            byp2_q  <= byp1_q;
            pass2_q <= pass1_q;
            sgn2_q  <= sgn1_q;
            out_q   <= out_d;
        end
    end

    assign pix_o = out_q;

endmodule

// File: rtl/csc_matrix.sv
// csc_matrix: 3x3 colour-space conversion with per-row offset and clamp.
// Holds the shadow/active configuration banks and the 3-deep sideband delay;
// the arithmetic lives in three csc_row instances.
// Ports:
//   clk, resetb                 clock, synchronous active-low reset
//   enable                      1 = convert, 0 = bypass (sampled per beat)
//   dvi, dtypei, i0..i2         input beat: valid, type code, channels
//   meta_datai                  sideband, delayed with the beat
//   cfg_we, cfg_addr, cfg_wdata shadow-bank write port
//   dvo, dtypeo, o0..o2         output beat, 3 cycles after input
//   meta_datao                  delayed sideband
//   cfg_pending                 shadow committed, waiting for frame start or bypass
module csc_matrix
    import csc_matrix_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned COEF_WIDTH  = 12,
    parameter int unsigned COEF_FRAC   = 8
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [PIXEL_WIDTH-1:0] i0,
    input  logic [PIXEL_WIDTH-1:0] i1,
    input  logic [PIXEL_WIDTH-1:0] i2,
    input  logic [15:0]            meta_datai,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [15:0]            cfg_wdata,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [PIXEL_WIDTH-1:0] o0,
    output logic [PIXEL_WIDTH-1:0] o1,
    output logic [PIXEL_WIDTH-1:0] o2,
    output logic [15:0]            meta_datao,
    output logic                   cfg_pending
);

    logic [NUM_COEF-1:0][COEF_WIDTH-1:0] def_coef;
    logic [NUM_COEF-1:0][COEF_WIDTH-1:0] sh_coef_d, sh_coef_q, act_coef_d, act_coef_q;
    logic [2:0][PIXEL_WIDTH:0]           sh_off_d, sh_off_q, act_off_d, act_off_q;
    logic [2:0]                          sh_sgn_d, sh_sgn_q, act_sgn_d, act_sgn_q;
    logic                                pending_d, pending_q;
    logic                                commit;
    logic                                xfer;

    logic [2:0]                          dv_d, dv_q;
    logic [2:0][DTYPE_WIDTH-1:0]         dt_d, dt_q;
    logic [2:0][15:0]                    meta_d, meta_q;

    logic [2:0][PIXEL_WIDTH-1:0]         pix;
    logic [2:0][PIXEL_WIDTH-1:0]         row_out;

    // Upper write-data bits beyond the field widths are intentionally ignored.
    logic unused_cfg_wdata;
    assign unused_cfg_wdata = ^cfg_wdata;

    always_comb begin
        for (int k = 0; k < NUM_COEF; k++) begin
            def_coef[k] = COEF_WIDTH'(default_coef(k, COEF_FRAC));
        end
    end

    // Shadow writes, commit and the shadow-to-active transfer.
    always_comb begin
        sh_coef_d = sh_coef_q;
        sh_off_d  = sh_off_q;
        sh_sgn_d  = sh_sgn_q;
        commit    = 1'b0;
        if (cfg_we) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                if (cfg_addr == 4'(k)) begin
                    sh_coef_d[k] = cfg_wdata[COEF_WIDTH-1:0];
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (cfg_addr == CfgAddrOff0 + 4'(k)) begin
                    sh_off_d[k] = cfg_wdata[PIXEL_WIDTH:0];
                end
            end
            if (cfg_addr == CfgAddrSigned) begin
                sh_sgn_d = cfg_wdata[2:0];
                commit   = 1'b1;
            end
            if (cfg_addr == CfgAddrCommit) begin
                commit = 1'b1;
            end
        end

        xfer = pending_q && ((dvi && (dtypei == DtypeFrameStart)) || !enable);

        // The beat accepted in the transfer cycle must already see the new bank,
        // including any shadow write landing in that same cycle.
        act_coef_d = xfer ? sh_coef_d : act_coef_q;
        act_off_d  = xfer ? sh_off_d  : act_off_q;
        act_sgn_d  = xfer ? sh_sgn_d  : act_sgn_q;

        if (xfer) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    always_comb begin
        dv_d   = {dv_q[1:0], dvi};
        dt_d   = {dt_q[1:0], dtypei};
        meta_d = {meta_q[1:0], meta_datai};
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            sh_coef_q  <= def_coef;
            act_coef_q <= def_coef;
            sh_off_q   <= '0;
            act_off_q  <= '0;
            sh_sgn_q   <= DefOutSigned;
            act_sgn_q  <= DefOutSigned;
            pending_q  <= 1'b0;
            dv_q       <= '0;
            dt_q       <= '0;
            meta_q     <= '0;
        end else begin
            sh_coef_q  <= sh_coef_d;
            act_coef_q <= act_coef_d;
            sh_off_q   <= sh_off_d;
            act_off_q  <= act_off_d;
            sh_sgn_q   <= sh_sgn_d;
            act_sgn_q  <= act_sgn_d;
            pending_q  <= pending_d;
            dv_q       <= dv_d;
            dt_q       <= dt_d;
            meta_q     <= meta_d;
        end
    end

    assign pix = {i2, i1, i0};

    for (genvar r = 0; r < 3; r++) begin : g_row
        csc_row #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH),
            .COEF_FRAC   (COEF_FRAC)
        ) u_row (
            .clk          (clk),
            .resetb       (resetb),
            .bypass_i     (!enable),
            .pix_i        (pix),
            .pass_i       (pix[r]),
            .coef_i       (act_coef_d[3*r +: 3]),
            .offset_i     (act_off_d[r]),
            .out_signed_i (act_sgn_d[r]),
            .pix_o        (row_out[r])
        );
    end

    assign o0          = row_out[0];
    assign o1          = row_out[1];
    assign o2          = row_out[2];
    assign dvo         = dv_q[2];
    assign dtypeo      = dt_q[2];
    assign meta_datao  = meta_q[2];
    assign cfg_pending = pending_q;

endmodule
